cpu7_exu_wbctl: RTL and testbench
=================================

CPU7_EXU_WBCTL -- requirements
Module: cpu7_exu_wbctl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports alu_wen_w / alu_rd_w / alu_data_w  input  1/5/GRLEN  ALU-pipe write-back request in W stage.
REQ-004 SHALL have ports lsu_issue_e / lsu_rd_e  input  1/5  long-latency op (load/div) issued in E, with its destination.
REQ-005 SHALL have ports lsu_res_valid / lsu_res_rd / lsu_res_data  input  1/5/GRLEN  long-latency result offer.
REQ-006 SHALL have port lsu_res_ready  output  1  result accepted when valid&&ready at the clock edge.
REQ-007 SHALL have ports dec_valid_d / dec_long_d / dec_rs1_d / dec_rs2_d / dec_rd_d  input  1/1/5/5/5  decode-stage instruction to check.
REQ-008 SHALL have port wbc_stall_d  output  1  holds decode.
REQ-009 SHALL have ports ecl_irf_wen_w / ecl_irf_rd_w / ecl_irf_rd_data_w  output  1/5/GRLEN  single register-file write port.

Function
REQ-010 SHALL treat the register-file write port as one shared resource: ALU request has absolute priority, ALU is never stalled.
REQ-011 SHALL buffer accepted long-latency results in a 2-entry FIFO; results leave in acceptance order.
REQ-012 SHALL drive lsu_res_ready = !reset && FIFO not full (combinational on current state).
REQ-013 SHALL, when ALU is not writing: write FIFO head if non-empty, else bypass an accepted lsu result the same cycle (zero latency); never bypass while FIFO non-empty.
REQ-014 SHALL, when ALU writes and a result is accepted the same cycle, enqueue it; latency to port is then >=1 cycle.
REQ-015 SHALL suppress ecl_irf_wen_w for rd=0 while still retiring the entry (dequeue, counter decrement).
REQ-016 SHALL keep a 32-bit pending scoreboard: set bit lsu_rd_e on lsu_issue_e (rd!=0); clear bit on long-path retirement to port.
REQ-017 SHALL, on same-cycle set and clear of the same bit, leave it set.
REQ-018 SHALL keep an outstanding counter 0..4: +1 on lsu_issue_e, -1 on long-path retirement, unchanged if both; rd=0 ops count.
REQ-019 SHALL assert wbc_stall_d when dec_valid_d and (pending[rs1] or pending[rs2] or pending[rd], r0 ignored) or (dec_long_d and counter==4).
REQ-020 SHALL treat lsu_issue_e with counter==4, or ALU write to a pending rd, as protocol errors (simulation assertion, no recovery).
REQ-021 SHALL drive ecl_irf_rd_w/ecl_irf_rd_data_w = 0 when ecl_irf_wen_w=0.

Reset
REQ-022 SHALL on reset clear scoreboard, counter, FIFO pointers; outputs wen=0, rd=0, data=0, ready=0, stall=0 while reset high.
REQ-023 SHALL discard any in-flight FIFO contents on reset mid-operation; no write occurs in the reset cycle.
REQ-024 SHALL present ready=1 in the first cycle after reset deasserts.

Structure
REQ-025 SHALL take GRLEN from common.vh; WBC_BUF_DEPTH=2 and WBC_MAX_OUTSTANDING=4 SHALL be shared constants in common.vh.
REQ-026 SHALL instantiate one sub-module cpu7_exu_wbc_fifo (2-entry, rd+data, full/empty flags); scoreboard and arbitration stay in the top.

Verification
REQ-027 Bypass: issue r5, then lsu_res (r5, 0x1234) with ALU idle -> same-cycle wen=1 rd=5 data=0x1234; pending[5] cleared next cycle.
REQ-028 Collision: ALU writes r3=0xA while lsu_res r7=0xB accepted -> cycle N r3/0xA, cycle N+1 r7/0xB.
REQ-029 Backpressure: ALU writes 3 consecutive cycles, 3 lsu results offered -> 2 accepted, ready=0 on third until first drain; order preserved.
REQ-030 Hazard: issue r9 load; decode rs2=9 -> stall=1 until r9 written, then stall=0 next cycle; rs1=0 with r0 issue never stalls.
REQ-031 Capacity: 4 long issues outstanding, decode dec_long_d=1 -> stall=1; one retirement -> stall drops; simultaneous issue+retire keeps count 4.
REQ-032 Reset mid-op: FIFO holding 2 entries, assert reset 1 cycle -> no writes, pending=0, ready=1 after release.

Source files
------------

// File: rtl/cpu7_exu_wbctl_pkg.sv
`default_nettype none
// ==========================================================================
// cpu7_exu_wbctl_pkg : shared write-back constants and types   (rev 1.0)
// ==========================================================================
package cpu7_exu_wbctl_pkg;

  localparam int GRLEN               = 32;
  localparam int WBC_BUF_DEPTH       = 2;
  localparam int WBC_MAX_OUTSTANDING = 4;
  localparam int CNT_W               = $clog2(WBC_MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [4:0]       rd;
    logic [GRLEN-1:0] data;
  } wb_req_t;

  // r0 is hardwired, so it maps to an empty mask everywhere it is used
  function automatic logic [31:0] rd_mask(input logic [4:0] rd);
    rd_mask = (rd == 5'd0) ? 32'd0 : (32'd1 << rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu7_exu_wbc_fifo.sv
`default_nettype none
// ==========================================================================
// cpu7_exu_wbc_fifo : small in-order buffer for long-latency results (rev 1.0)
// ==========================================================================
module cpu7_exu_wbc_fifo
  import cpu7_exu_wbctl_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_entry,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = (WBC_BUF_DEPTH > 1) ? $clog2(WBC_BUF_DEPTH) : 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  wb_req_t       mem_q [WBC_BUF_DEPTH];
  wb_req_t       mem_d [WBC_BUF_DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == (PW+1)'(WBC_BUF_DEPTH));
  assign empty = (cnt_q == '0);

  // Storage carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu7_exu_wbctl.sv
`default_nettype none
// ==========================================================================
// cpu7_exu_wbctl : register-file write-port arbiter + pending scoreboard (rev 1.0)
// ==========================================================================
module cpu7_exu_wbctl
  import cpu7_exu_wbctl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_wen_w,
  input  logic [4:0]       alu_rd_w,
  input  logic [GRLEN-1:0] alu_data_w,
  input  logic             lsu_issue_e,
  input  logic [4:0]       lsu_rd_e,
  input  logic             lsu_res_valid,
  input  logic [4:0]       lsu_res_rd,
  input  logic [GRLEN-1:0] lsu_res_data,
  output logic             lsu_res_ready,
  input  logic             dec_valid_d,
  input  logic             dec_long_d,
  input  logic [4:0]       dec_rs1_d,
  input  logic [4:0]       dec_rs2_d,
  input  logic [4:0]       dec_rd_d,
  output logic             wbc_stall_d,
  output logic             ecl_irf_wen_w,
  output logic [4:0]       ecl_irf_rd_w,
  output logic [GRLEN-1:0] ecl_irf_rd_data_w
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WBC_MAX_OUTSTANDING);

  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  wb_req_t fifo_head, res_entry, long_req;
  logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic    res_accept, bypass, retire;

  cpu7_exu_wbc_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (res_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    res_entry     = '{rd: lsu_res_rd, data: lsu_res_data};
    lsu_res_ready = !reset && !fifo_full;
    res_accept    = lsu_res_valid && lsu_res_ready;

    // ALU owns the port; a buffered result always beats a fresh one
    fifo_pop  = !reset && !alu_wen_w && !fifo_empty;
    bypass    = !alu_wen_w && fifo_empty && res_accept;
    fifo_push = res_accept && !bypass;
    retire    = fifo_pop || bypass;
    long_req  = fifo_pop ? fifo_head : res_entry;

    ecl_irf_wen_w     = 1'b0;
    ecl_irf_rd_w      = '0;
    ecl_irf_rd_data_w = '0;
    if (!reset) begin
      if (alu_wen_w) begin
        if (alu_rd_w != 5'd0) begin
          ecl_irf_wen_w     = 1'b1;
          ecl_irf_rd_w      = alu_rd_w;
          ecl_irf_rd_data_w = alu_data_w;
        end
      end else if (retire && long_req.rd != 5'd0) begin
        ecl_irf_wen_w     = 1'b1;
        ecl_irf_rd_w      = long_req.rd;
        ecl_irf_rd_data_w = long_req.data;
      end
    end

    // Set is applied after clear so a same-cycle re-issue stays pending
    pending_d = (pending_q & ~(retire ? rd_mask(long_req.rd) : 32'd0))
              | (lsu_issue_e ? rd_mask(lsu_rd_e) : 32'd0);
    cnt_d     = cnt_q + CNT_W'(lsu_issue_e) - CNT_W'(retire);

    wbc_stall_d = !reset && dec_valid_d &&
                  ((|(pending_q & (rd_mask(dec_rs1_d) | rd_mask(dec_rs2_d) | rd_mask(dec_rd_d))))
                   || (dec_long_d && cnt_q == CNT_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // An issue at the limit is legal only when a retirement frees a slot that cycle
  a_issue_overflow: assert property (@(posedge clk) disable iff (reset)
    !(lsu_issue_e && cnt_q == CNT_MAX && !retire));
  a_alu_pending_rd: assert property (@(posedge clk) disable iff (reset)
    !(alu_wen_w && pending_q[alu_rd_w]));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu7_exu_wbctl.sv
`default_nettype none
// ==========================================================================
// tb_cpu7_exu_wbctl : directed self-checking bench for cpu7_exu_wbctl (rev 1.0)
// ==========================================================================
module tb_cpu7_exu_wbctl;
  import cpu7_exu_wbctl_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_wen_w;
  logic [4:0]       alu_rd_w;
  logic [GRLEN-1:0] alu_data_w;
  logic             lsu_issue_e;
  logic [4:0]       lsu_rd_e;
  logic             lsu_res_valid;
  logic [4:0]       lsu_res_rd;
  logic [GRLEN-1:0] lsu_res_data;
  logic             lsu_res_ready;
  logic             dec_valid_d, dec_long_d;
  logic [4:0]       dec_rs1_d, dec_rs2_d, dec_rd_d;
  logic             wbc_stall_d;
  logic             ecl_irf_wen_w;
  logic [4:0]       ecl_irf_rd_w;
  logic [GRLEN-1:0] ecl_irf_rd_data_w;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu7_exu_wbctl dut (
    .clk               (clk),
    .reset             (reset),
    .alu_wen_w         (alu_wen_w),
    .alu_rd_w          (alu_rd_w),
    .alu_data_w        (alu_data_w),
    .lsu_issue_e       (lsu_issue_e),
    .lsu_rd_e          (lsu_rd_e),
    .lsu_res_valid     (lsu_res_valid),
    .lsu_res_rd        (lsu_res_rd),
    .lsu_res_data      (lsu_res_data),
    .lsu_res_ready     (lsu_res_ready),
    .dec_valid_d       (dec_valid_d),
    .dec_long_d        (dec_long_d),
    .dec_rs1_d         (dec_rs1_d),
    .dec_rs2_d         (dec_rs2_d),
    .dec_rd_d          (dec_rd_d),
    .wbc_stall_d       (wbc_stall_d),
    .ecl_irf_wen_w     (ecl_irf_wen_w),
    .ecl_irf_rd_w      (ecl_irf_rd_w),
    .ecl_irf_rd_data_w (ecl_irf_rd_data_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic wen, input logic [4:0] rd,
                          input logic [31:0] data);
    chk({tag, ".wen"},  32'(ecl_irf_wen_w),     32'(wen));
    chk({tag, ".rd"},   32'(ecl_irf_rd_w),      32'(rd));
    chk({tag, ".data"}, 32'(ecl_irf_rd_data_w), data);
  endtask

  task automatic idle();
    alu_wen_w = 0; alu_rd_w = 0; alu_data_w = 0;
    lsu_issue_e = 0; lsu_rd_e = 0;
    lsu_res_valid = 0; lsu_res_rd = 0; lsu_res_data = 0;
    dec_valid_d = 0; dec_long_d = 0; dec_rs1_d = 0; dec_rs2_d = 0; dec_rd_d = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_wen_w = 1; alu_rd_w = rd; alu_data_w = d;
  endtask

  task automatic res(input logic [4:0] rd, input logic [31:0] d);
    lsu_res_valid = 1; lsu_res_rd = rd; lsu_res_data = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    lsu_issue_e = 1; lsu_rd_e = rd;
  endtask

  task automatic dec(input logic lng, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd);
    dec_valid_d = 1; dec_long_d = lng; dec_rs1_d = rs1; dec_rs2_d = rs2; dec_rd_d = rd;
  endtask

  initial begin
    // Reset: outputs stay quiet even with an ALU write and a result offered
    reset = 1; idle();
    step();
    alu(5'd4, 32'h5); res(5'd6, 32'h66); dec(1'b1, 5'd1, 5'd2, 5'd3);
    step(); #1;
    chk_port("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.ready", 32'(lsu_res_ready), 32'd0);
    chk("rst.stall", 32'(wbc_stall_d), 32'd0);
    step();
    reset = 0; idle(); #1;
    chk("post_rst.ready", 32'(lsu_res_ready), 32'd1);
    chk_port("post_rst", 1'b0, 5'd0, 32'h0);

    // Bypass
    step(); issue(5'd5); dec(1'b0, 5'd5, 5'd0, 5'd0); #1;
    chk("byp.stall_pre", 32'(wbc_stall_d), 32'd0);
    step(); idle(); dec(1'b0, 5'd0, 5'd5, 5'd0); #1;
    chk("byp.stall_pend", 32'(wbc_stall_d), 32'd1);
    res(5'd5, 32'h1234); #1;
    chk_port("byp", 1'b1, 5'd5, 32'h1234);
    chk("byp.stall_same", 32'(wbc_stall_d), 32'd1);
    step(); idle(); dec(1'b0, 5'd0, 5'd5, 5'd0); #1;
    chk("byp.stall_clr", 32'(wbc_stall_d), 32'd0);
    chk_port("byp.after", 1'b0, 5'd0, 32'h0);

    // Collision: ALU wins, result follows a cycle later
    step(); idle(); issue(5'd7); #1;
    step(); idle(); alu(5'd3, 32'hA); res(5'd7, 32'hB); #1;
    chk_port("col.n", 1'b1, 5'd3, 32'hA);
    step(); idle(); dec(1'b0, 5'd7, 5'd0, 5'd0); #1;
    chk_port("col.n1", 1'b1, 5'd7, 32'hB);
    chk("col.stall_n1", 32'(wbc_stall_d), 32'd1);
    step(); #1;
    chk_port("col.n2", 1'b0, 5'd0, 32'h0);
    chk("col.stall_n2", 32'(wbc_stall_d), 32'd0);

    // Backpressure
    step(); idle(); issue(5'd10);
    step(); issue(5'd11);
    step(); issue(5'd12);
    step(); idle(); alu(5'd1, 32'h11); res(5'd10, 32'h100); #1;
    chk("bp.c1.ready", 32'(lsu_res_ready), 32'd1);
    chk_port("bp.c1", 1'b1, 5'd1, 32'h11);
    step(); alu(5'd2, 32'h22); res(5'd11, 32'h101); #1;
    chk("bp.c2.ready", 32'(lsu_res_ready), 32'd1);
    step(); alu(5'd3, 32'h33); res(5'd12, 32'h102); #1;
    chk("bp.c3.ready", 32'(lsu_res_ready), 32'd0);
    chk_port("bp.c3", 1'b1, 5'd3, 32'h33);
    step(); alu_wen_w = 0; #1;
    chk("bp.c4.ready", 32'(lsu_res_ready), 32'd0);
    chk_port("bp.c4", 1'b1, 5'd10, 32'h100);
    step(); #1;
    chk("bp.c5.ready", 32'(lsu_res_ready), 32'd1);
    chk_port("bp.c5", 1'b1, 5'd11, 32'h101);
    step(); idle(); #1;
    chk_port("bp.c6", 1'b1, 5'd12, 32'h102);
    step(); #1;
    chk_port("bp.c7", 1'b0, 5'd0, 32'h0);

    // Hazard on r9; r0 is never tracked
    step(); idle(); issue(5'd9);
    step(); idle(); issue(5'd0); dec(1'b0, 5'd0, 5'd4, 5'd6); #1;
    chk("hz.r0_free", 32'(wbc_stall_d), 32'd0);
    dec(1'b0, 5'd0, 5'd9, 5'd0); #1;
    chk("hz.rs2_9", 32'(wbc_stall_d), 32'd1);
    step(); lsu_issue_e = 0; #1;
    chk("hz.hold", 32'(wbc_stall_d), 32'd1);
    dec_valid_d = 0; #1;
    chk("hz.not_valid", 32'(wbc_stall_d), 32'd0);
    dec_valid_d = 1;
    step(); res(5'd9, 32'h99); #1;
    chk_port("hz.wr9", 1'b1, 5'd9, 32'h99);
    chk("hz.stall_wr", 32'(wbc_stall_d), 32'd1);
    step(); lsu_res_valid = 0; #1;
    chk("hz.released", 32'(wbc_stall_d), 32'd0);
    step(); idle(); res(5'd0, 32'h77); #1;
    chk_port("hz.rd0", 1'b0, 5'd0, 32'h0);

    // Capacity
    step(); idle(); issue(5'd20);
    step(); issue(5'd21);
    step(); issue(5'd22);
    step(); idle(); dec(1'b1, 5'd0, 5'd0, 5'd0); #1;
    chk("cap.three", 32'(wbc_stall_d), 32'd0);
    issue(5'd23);
    step(); lsu_issue_e = 0; #1;
    chk("cap.full", 32'(wbc_stall_d), 32'd1);
    dec_long_d = 0; #1;
    chk("cap.nolong", 32'(wbc_stall_d), 32'd0);
    dec_long_d = 1;
    step(); res(5'd20, 32'h20); issue(5'd24); #1;
    chk_port("cap.ret20", 1'b1, 5'd20, 32'h20);
    step(); lsu_res_valid = 0; lsu_issue_e = 0; #1;
    chk("cap.issue_retire", 32'(wbc_stall_d), 32'd1);
    res(5'd21, 32'h21); #1;
    chk_port("cap.ret21", 1'b1, 5'd21, 32'h21);
    step(); lsu_res_valid = 0; #1;
    chk("cap.after_retire", 32'(wbc_stall_d), 32'd0);

    // Reset with two buffered results
    step(); idle(); alu(5'd8, 32'h88); res(5'd22, 32'h222); #1;
    chk("mr.ready1", 32'(lsu_res_ready), 32'd1);
    step(); alu(5'd1, 32'h11); res(5'd23, 32'h233); #1;
    chk("mr.ready2", 32'(lsu_res_ready), 32'd1);
    step(); reset = 1; alu(5'd8, 32'h88); res(5'd24, 32'h244); dec(1'b0, 5'd22, 5'd0, 5'd0); #1;
    chk_port("mr.rst", 1'b0, 5'd0, 32'h0);
    chk("mr.rst_ready", 32'(lsu_res_ready), 32'd0);
    chk("mr.rst_stall", 32'(wbc_stall_d), 32'd0);
    step(); reset = 0; idle(); dec(1'b1, 5'd24, 5'd23, 5'd22); #1;
    chk("mr.ready", 32'(lsu_res_ready), 32'd1);
    chk_port("mr.rel", 1'b0, 5'd0, 32'h0);
    chk("mr.pending_clr", 32'(wbc_stall_d), 32'd0);
    step(); #1;
    chk_port("mr.rel2", 1'b0, 5'd0, 32'h0);

    step(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end of test, expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
